// File: rtl/arith_unit.sv
// Arithmetic-unit datapath: A, B (with overflow bit) and C magnitude registers driven by
// one-cycle micro-op pulses. Spec bit k (1 = MSB, W = LSB, 0 = overflow) lives at index W-k.
module arith_unit #(
   parameter int unsigned W = 30
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         do_clear_a_from_ac,
   input  logic         do_clear_b_from_ac,
   input  logic         do_clear_c_from_ac,
   input  logic         do_not_a_from_ac,
   input  logic         do_not_b_from_ac,
   input  logic         do_sum_from_ac,
   input  logic         do_and_from_ac,
   input  logic         do_set_c_30_from_ac,
   input  logic         do_left_shift_b_from_ac,
   input  logic         do_left_shift_c_from_ac,
   input  logic         do_left_shift_c29_from_ac,
   input  logic         do_right_shift_bc_from_ac,
   input  logic         do_move_c_to_a_from_ac,
   input  logic         do_move_c_to_b_from_ac,
   input  logic         do_move_b_to_c_from_ac,
   input  logic         do_read_mem_from_mem,
   input  logic [W-1:0] mem_read_data_from_mem,
   input  logic         do_arr_c_from_pnl,
   input  logic [W-1:0] arr_reg_c_from_pnl,
   output logic         carry_out_to_ac,
   output logic         reg_c_1_to_ac,
   output logic         reg_c_30_to_ac,
   output logic         reg_b_0_to_ac,
   output logic [W-1:0] mem_write_data_to_mem,
   output logic [W-1:0] reg_c_to_io,
   output logic [W:0]   reg_a_to_pnl,
   output logic [W:0]   reg_b_to_pnl,
   output logic [W-1:0] reg_c_to_pnl
);

   logic [W:0]   a_q, a_d;
   logic [W:0]   b_q, b_d;
   logic [W-1:0] c_q, c_d;
   logic [W:0]   sum_s;
   logic         sum_cy;
   logic         fill_b, fill_c;

   always_comb begin
      {sum_cy, sum_s} = {1'b0, a_q} + {1'b0, b_q};
   end

   // C[1] feeds the B shift when c29 is set; C rotates only when B is not shifting with it.
   assign fill_b = do_left_shift_c29_from_ac & c_q[W-1];
   assign fill_c = do_left_shift_c29_from_ac & ~do_left_shift_b_from_ac & c_q[W-1];

   always_comb begin
      a_d = a_q;
      if (do_clear_a_from_ac) begin
         a_d = '0;
      end else if (do_move_c_to_a_from_ac) begin
         a_d = {1'b0, c_q};
      end else if (do_not_a_from_ac) begin
         a_d = ~a_q;
      end
   end

   always_comb begin
      b_d = b_q;
      if (do_clear_b_from_ac) begin
         b_d = '0;
      end else if (do_move_c_to_b_from_ac) begin
         b_d = {1'b0, c_q};
      end else if (do_sum_from_ac) begin
         b_d = sum_s + {{W{1'b0}}, sum_cy};
      end else if (do_left_shift_b_from_ac) begin
         b_d = {b_q[W-1:0], fill_b};
      end else if (do_right_shift_bc_from_ac) begin
         b_d = {1'b0, b_q[W:1]};
      end else if (do_not_b_from_ac) begin
         b_d = ~b_q;
      end
   end

   always_comb begin
      c_d = c_q;
      if (do_clear_c_from_ac) begin
         c_d = '0;
      end else if (do_move_b_to_c_from_ac) begin
         c_d = b_q[W-1:0];
      end else if (do_and_from_ac) begin
         c_d = a_q[W-1:0] & c_q;
      end else if (do_read_mem_from_mem) begin
         c_d = mem_read_data_from_mem;
      end else if (do_arr_c_from_pnl) begin
         c_d = arr_reg_c_from_pnl;
      end else if (do_left_shift_c_from_ac) begin
         c_d = {c_q[W-2:0], fill_c};
      end else if (do_right_shift_bc_from_ac) begin
         c_d = {b_q[0], c_q[W-1:1]};
      end
      // Quotient bit lands on top of whichever update was selected.
      if (do_set_c_30_from_ac) begin
         c_d[0] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
      end
   end

   assign carry_out_to_ac       = sum_cy;
   assign reg_c_1_to_ac         = c_q[W-1];
   assign reg_c_30_to_ac        = c_q[0];
   assign reg_b_0_to_ac         = b_q[W];
   assign mem_write_data_to_mem = c_q;
   assign reg_c_to_io           = c_q;
   assign reg_a_to_pnl          = a_q;
   assign reg_b_to_pnl          = b_q;
   assign reg_c_to_pnl          = c_q;

endmodule

// File: tb/tb_arith_unit.sv
// Self-checking bench for arith_unit: directed vector table, multi-cycle sequences and
// randomized micro-op streams against an arithmetic reference model.
module tb_arith_unit;

   localparam int unsigned W = 30;
   localparam longint unsigned M31 = 64'h7FFF_FFFF;
   localparam longint unsigned M30 = 64'h3FFF_FFFF;

   localparam logic [16:0] O_CLR_A = 17'd1 << 0;
   localparam logic [16:0] O_CLR_B = 17'd1 << 1;
   localparam logic [16:0] O_CLR_C = 17'd1 << 2;
   localparam logic [16:0] O_NOT_A = 17'd1 << 3;
   localparam logic [16:0] O_NOT_B = 17'd1 << 4;
   localparam logic [16:0] O_SUM   = 17'd1 << 5;
   localparam logic [16:0] O_AND   = 17'd1 << 6;
   localparam logic [16:0] O_SET30 = 17'd1 << 7;
   localparam logic [16:0] O_LSB   = 17'd1 << 8;
   localparam logic [16:0] O_LSC   = 17'd1 << 9;
   localparam logic [16:0] O_C29   = 17'd1 << 10;
   localparam logic [16:0] O_RS    = 17'd1 << 11;
   localparam logic [16:0] O_MCA   = 17'd1 << 12;
   localparam logic [16:0] O_MCB   = 17'd1 << 13;
   localparam logic [16:0] O_MBC   = 17'd1 << 14;
   localparam logic [16:0] O_RD    = 17'd1 << 15;
   localparam logic [16:0] O_ARR   = 17'd1 << 16;

   logic clk = 1'b0;
   logic reset;
   logic [16:0] op;
   logic [W-1:0] mem_data, arr_data;
   logic carry_out, c_1, c_30, b_0;
   logic [W-1:0] mem_wr, c_io, c_pnl;
   logic [W:0] a_pnl, b_pnl;

   int total_cnt = 0;
   int pass_cnt = 0;

   longint unsigned ma, mb, mc;
   logic cy_dut_pre;
   longint unsigned cy_mdl_pre;

   always #5 clk = ~clk;

   arith_unit #(.W(W)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .do_clear_a_from_ac        (op[0]),
      .do_clear_b_from_ac        (op[1]),
      .do_clear_c_from_ac        (op[2]),
      .do_not_a_from_ac          (op[3]),
      .do_not_b_from_ac          (op[4]),
      .do_sum_from_ac            (op[5]),
      .do_and_from_ac            (op[6]),
      .do_set_c_30_from_ac       (op[7]),
      .do_left_shift_b_from_ac   (op[8]),
      .do_left_shift_c_from_ac   (op[9]),
      .do_left_shift_c29_from_ac (op[10]),
      .do_right_shift_bc_from_ac (op[11]),
      .do_move_c_to_a_from_ac    (op[12]),
      .do_move_c_to_b_from_ac    (op[13]),
      .do_move_b_to_c_from_ac    (op[14]),
      .do_read_mem_from_mem      (op[15]),
      .mem_read_data_from_mem    (mem_data),
      .do_arr_c_from_pnl         (op[16]),
      .arr_reg_c_from_pnl        (arr_data),
      .carry_out_to_ac           (carry_out),
      .reg_c_1_to_ac             (c_1),
      .reg_c_30_to_ac            (c_30),
      .reg_b_0_to_ac             (b_0),
      .mem_write_data_to_mem     (mem_wr),
      .reg_c_to_io               (c_io),
      .reg_a_to_pnl              (a_pnl),
      .reg_b_to_pnl              (b_pnl),
      .reg_c_to_pnl              (c_pnl)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Registers as plain numbers: A, B are 31-bit values (overflow is the top bit), C is 30-bit.
   task automatic model_apply(input logic [16:0] o, input logic [W-1:0] mem,
                              input logic [W-1:0] arr, input bit rst);
      longint unsigned s, cy, c1, fb, fc, na, nb, nc;
      s  = ma + mb;
      cy = s >> 31;
      s  = s & M31;
      c1 = (mc >> 29) & 1;
      fb = (o & O_C29) != 0 ? c1 : 0;
      fc = ((o & O_C29) != 0 && (o & O_LSB) == 0) ? c1 : 0;
      na = ma; nb = mb; nc = mc;
      if ((o & O_CLR_A) != 0)      na = 0;
      else if ((o & O_MCA) != 0)   na = mc;
      else if ((o & O_NOT_A) != 0) na = ma ^ M31;
      if ((o & O_CLR_B) != 0)      nb = 0;
      else if ((o & O_MCB) != 0)   nb = mc;
      else if ((o & O_SUM) != 0)   nb = (s + cy) & M31;
      else if ((o & O_LSB) != 0)   nb = ((mb << 1) | fb) & M31;
      else if ((o & O_RS) != 0)    nb = mb >> 1;
      else if ((o & O_NOT_B) != 0) nb = mb ^ M31;
      if ((o & O_CLR_C) != 0)      nc = 0;
      else if ((o & O_MBC) != 0)   nc = mb & M30;
      else if ((o & O_AND) != 0)   nc = ma & mc & M30;
      else if ((o & O_RD) != 0)    nc = longint'(mem);
      else if ((o & O_ARR) != 0)   nc = longint'(arr);
      else if ((o & O_LSC) != 0)   nc = ((mc << 1) | fc) & M30;
      else if ((o & O_RS) != 0)    nc = (mc >> 1) | ((mb & 1) << 29);
      if ((o & O_SET30) != 0) nc = nc | 1;
      if (rst) begin
         na = 0; nb = 0; nc = 0;
      end
      ma = na; mb = nb; mc = nc;
   endtask

   // One clock with the given pulses; carry is captured just before the edge.
   task automatic step(input logic [16:0] o, input logic [W-1:0] mem = '0,
                       input logic [W-1:0] arr = '0, input bit rst = 1'b0);
      op = o; mem_data = mem; arr_data = arr; reset = rst;
      #1;
      cy_dut_pre = carry_out;
      cy_mdl_pre = ((ma + mb) >> 31) & 1;
      model_apply(o, mem, arr, rst);
      @(posedge clk);
      #1;
      op = '0; mem_data = '0; arr_data = '0; reset = 1'b0;
   endtask

   task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input bit inv_a);
      step(O_CLR_A | O_CLR_B | O_CLR_C);
      step(O_RD, a);
      step(O_MCA);
      step(O_RD, b);
      step(O_MCB);
      if (inv_a) step(O_NOT_A);
      step(O_RD, c);
   endtask

   typedef struct {
      string       name;
      logic [29:0] a, b, c;
      bit          inv_a;
      logic [16:0] ops;
      logic [29:0] mem, arr;
      logic [30:0] exp_a, exp_b;
      logic [29:0] exp_c;
      bit          exp_cy;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{"sum",        30'd5, 30'd3, 30'd0, 0, O_SUM, 0, 0,
                   31'd5, 31'd8, 30'd0, 0};
      vecs[1]  = '{"sum_eac",    30'd0, 30'd1, 30'd0, 1, O_SUM, 0, 0,
                   31'h7FFFFFFF, 31'd1, 30'd0, 1};
      vecs[2]  = '{"sub",        30'd7, 30'd10, 30'd0, 1, O_SUM, 0, 0,
                   31'h7FFFFFF8, 31'd3, 30'd0, 1};
      vecs[3]  = '{"div_shift",  30'd0, 30'd2, 30'h20000001, 0, O_LSB | O_LSC | O_C29, 0, 0,
                   31'd0, 31'd5, 30'd2, 0};
      vecs[4]  = '{"rot_c",      30'd0, 30'd0, 30'h20000000, 0, O_LSC | O_C29, 0, 0,
                   31'd0, 31'd0, 30'd1, 0};
      vecs[5]  = '{"mem_wins",   30'd0, 30'd0, 30'd0, 0, O_RD | O_ARR, 30'h1234567, 30'h3ABCDEF,
                   31'd0, 31'd0, 30'h1234567, 0};
      vecs[6]  = '{"not_ab",     30'd5, 30'd3, 30'd0, 0, O_NOT_A | O_NOT_B, 0, 0,
                   31'h7FFFFFFA, 31'h7FFFFFFC, 30'd0, 0};
      vecs[7]  = '{"swap",       30'd1, 30'd2, 30'd3, 0, O_MCA | O_MBC, 0, 0,
                   31'd3, 31'd2, 30'd2, 0};
      vecs[8]  = '{"and",        30'h0F0F, 30'd0, 30'h0FF0, 0, O_AND, 0, 0,
                   31'h0F0F, 31'd0, 30'h0F00, 0};
      vecs[9]  = '{"rshift",     30'd0, 30'd3, 30'd4, 0, O_RS, 0, 0,
                   31'd0, 31'd1, 30'h20000002, 0};
      vecs[10] = '{"clr_b_prio", 30'd1, 30'd1, 30'd0, 0, O_CLR_B | O_SUM, 0, 0,
                   31'd1, 31'd0, 30'd0, 0};
      vecs[11] = '{"sum_set30",  30'd1, 30'd1, 30'd0, 0, O_SUM | O_SET30, 0, 0,
                   31'd1, 31'd2, 30'd1, 0};
      vecs[12] = '{"lsb_ovf",    30'd0, 30'h20000000, 30'd0, 0, O_LSB, 0, 0,
                   31'd0, 31'h40000000, 30'd0, 0};
      vecs[13] = '{"c_prio",     30'd3, 30'd9, 30'd5, 0, O_MBC | O_AND | O_RD, 30'h77, 0,
                   31'd3, 31'd9, 30'd9, 0};
      vecs[14] = '{"lsc_plain",  30'd0, 30'd0, 30'h20000003, 0, O_LSC, 0, 0,
                   31'd0, 31'd0, 30'd6, 0};
      vecs[15] = '{"a_prio",     30'd5, 30'd0, 30'd9, 0, O_MCA | O_NOT_A, 0, 0,
                   31'd9, 31'd0, 30'd9, 0};
   end

   initial begin
      logic [16:0] rop;
      ma = 0; mb = 0; mc = 0;
      op = '0; mem_data = '0; arr_data = '0; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("reset_a", 64'(a_pnl), 64'd0);
      chk("reset_b", 64'(b_pnl), 64'd0);
      chk("reset_c", 64'(c_pnl), 64'd0);
      chk("reset_carry", 64'(carry_out), 64'd0);

      foreach (vecs[i]) begin
         load(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].inv_a);
         step(vecs[i].ops, vecs[i].mem, vecs[i].arr);
         chk({vecs[i].name, "_carry"}, 64'(cy_dut_pre), 64'(vecs[i].exp_cy));
         chk({vecs[i].name, "_a"}, 64'(a_pnl), 64'(vecs[i].exp_a));
         chk({vecs[i].name, "_b"}, 64'(b_pnl), 64'(vecs[i].exp_b));
         chk({vecs[i].name, "_c"}, 64'(c_pnl), 64'(vecs[i].exp_c));
         chk({vecs[i].name, "_c_ports"}, {2'b0, mem_wr, c_io},
             {2'b0, vecs[i].exp_c, vecs[i].exp_c});
         chk({vecs[i].name, "_status"}, 64'({c_1, c_30, b_0}),
             64'({vecs[i].exp_c[29], vecs[i].exp_c[0], vecs[i].exp_b[30]}));
      end

      // Shift-and-add multiply 3 x 5.
      load(30'd3, 30'd0, 30'd5, 0);
      for (int i = 0; i < 30; i++) begin
         if ((mc & 1) != 0) step(O_SUM);
         step(O_RS);
      end
      chk("mul_b", 64'(b_pnl), 64'd0);
      chk("mul_c", 64'(c_pnl), 64'd15);

      // Division step: shift with C[1] coupling, then subtract-style sum with quotient bit.
      load(30'd1, 30'd2, 30'h20000001, 0);
      step(O_LSB | O_LSC | O_C29);
      chk("div_b", 64'(b_pnl), 64'd5);
      step(O_SUM | O_SET30);
      chk("div_b2", 64'(b_pnl), 64'd6);
      chk("div_c30", 64'(c_30), 64'd1);
      chk("div_c", 64'(c_pnl), 64'd3);

      load(30'd5, 30'd7, 30'd9, 0);
      step(O_LSB | O_LSC | O_C29 | O_RS, 0, 0, 1'b1);
      chk("rst_mid_op", {a_pnl, b_pnl, 2'b0}, 64'd0);
      chk("rst_mid_op_c", 64'(c_pnl), 64'd0);

      for (int n = 0; n < 400; n++) begin
         rop = '0;
         repeat ($urandom_range(1, 3)) rop = rop | (17'd1 << $urandom_range(0, 16));
         step(rop, W'($urandom), W'($urandom), $urandom_range(0, 49) == 0);
         chk("rand_carry", 64'(cy_dut_pre), cy_mdl_pre);
         chk("rand_state", {a_pnl, b_pnl, 2'b0}, {ma[30:0], mb[30:0], 2'b0});
         chk("rand_c", 64'(c_pnl), mc);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
